serial_xfer_ctrl: RTL and testbench
===================================

Name: serial_xfer_ctrl

Overview:
- Sequencer for the link-port shift register (SB/SC): times each 8-bit transfer, generates the internal shift clock or follows the external one, and issues per-bit shift and output-load strobes.
- Signals completion so the register block clears SC[7] and the interrupt controller latches the serial interrupt.
- Sits between the SB/SC register logic and the link-port pins.

Parameters:
- DIV_NORMAL, 512, I_CLK cycles per serial bit in normal internal mode (4.194304 MHz / 8192 Hz); even, >=4.
- DIV_FAST, 16, I_CLK cycles per bit in CGB fast internal mode (262144 Hz); even, >=4.
- CNT_W, 9, half-period counter width; must hold DIV_NORMAL/2-1.

Ports:
- I_CLK  in  1  system clock
- I_RESET_L  in  1  asynchronous active-low reset
- I_START  in  1  one-cycle pulse: SC written with bit7=1
- I_INTERNAL  in  1  SC[0], sampled on accepted I_START
- I_FAST  in  1  SC[1], sampled on accepted I_START
- I_ABORT  in  1  one-cycle pulse: SC written with bit7=0
- I_EXTERNAL_CLOCK  in  1  link-port clock pin, asynchronous
- O_SERIAL_CLOCK  out  1  internal shift clock to pin
- O_OUT_LOAD  out  1  one-cycle pulse: drive SB[7] onto output pin (falling edge)
- O_SHIFT  out  1  one-cycle pulse: SB <= {SB[6:0], serial_in} (rising edge)
- O_BUSY  out  1  transfer in progress
- O_DONE  out  1  one-cycle pulse: clear SC[7]
- O_SERIAL_INTERRUPT  out  1  one-cycle interrupt request
- O_BIT_COUNT  out  3  bits completed in the current transfer

Behaviour:
- Reset is asynchronous and active-low (I_RESET_L). All outputs go to 0, state IDLE, counters 0, synchronizer flops 0.
- States: IDLE, LOW, HIGH (internal clock), EXT (external clock).
- IDLE:
  - I_START with I_INTERNAL=1: latch I_FAST, load half = DIV/2-1 (DIV per latched speed), go LOW.
  - I_START with I_INTERNAL=0: go EXT.
  - O_BUSY=0 only in IDLE.
- LOW:
  - O_SERIAL_CLOCK=0.
  - O_OUT_LOAD pulses in the first cycle of each LOW.
  - The half counter decrements each cycle. At 0, reload and go HIGH.
- HIGH:
  - O_SERIAL_CLOCK=1.
  - O_SHIFT pulses in the first cycle of each HIGH.
  - At counter 0, O_BIT_COUNT increments (3-bit, wraps 7->0). If that was bit 8, go IDLE; otherwise reload and go LOW.
- Internal transfer timing:
  - Bit k LOW entry at cycle 1+k*DIV, HIGH entry at 1+k*DIV+DIV/2.
  - Total 8*DIV cycles.
- EXT:
  - I_EXTERNAL_CLOCK passes through a 2-flop synchronizer plus an edge-detect flop.
  - Detected falling edge -> O_OUT_LOAD pulse.
  - Detected rising edge -> O_SHIFT pulse and bit increment.
  - O_SERIAL_CLOCK held 0.
  - An external transfer never completes without 8 rising edges.
- Completion:
  - In the cycle after the 8th bit ends, state is IDLE with O_DONE=1 and O_SERIAL_INTERRUPT=1 for exactly one cycle.
  - O_BUSY=0 and O_BIT_COUNT=0 in that cycle.
- I_START while busy is ignored; speed and mode do not change mid-transfer.
- I_ABORT:
  - In any non-IDLE state: go IDLE next cycle, O_SERIAL_CLOCK=0, O_BIT_COUNT=0, no O_DONE, no interrupt.
  - I_ABORT has priority over I_START in the same cycle.
  - I_ABORT in IDLE has no effect.
- Simultaneous external rising edge and I_ABORT: the abort wins and no O_SHIFT is issued.
- Reset asserted mid-transfer: immediate return to IDLE, no O_DONE or interrupt pulse afterwards.
- O_OUT_LOAD and O_SHIFT are never asserted in the same cycle.

Test Plan:
- Internal normal: I_START with I_INTERNAL=1, I_FAST=0 at cycle 0 -> O_OUT_LOAD at cycles 1,513,…,3585; O_SHIFT at 257,…,3841; O_DONE and O_SERIAL_INTERRUPT only at cycle 4097; O_BUSY high on cycles 1–4096.
- Internal fast: I_FAST=1 -> O_SERIAL_CLOCK period 16 cycles, 8 O_SHIFT pulses, O_DONE at cycle 129; O_BIT_COUNT runs 0..7 and returns to 0.
- External: I_INTERNAL=0, drive 8 clock pulses of 40 cycles each, asynchronous to I_CLK -> 8 O_OUT_LOAD and 8 O_SHIFT pulses, each 2–3 cycles after the pin edge; O_SERIAL_CLOCK stays 0; O_DONE and interrupt once after the 8th rise. With only 7 pulses, O_BUSY stays 1 indefinitely.
- Abort: internal normal, I_ABORT at cycle 1000 -> IDLE at 1001, O_BIT_COUNT=0, no O_DONE or interrupt through cycle 5000. I_ABORT and I_START in the same busy cycle -> IDLE.
- Restart ignored: second I_START (I_FAST=1) at cycle 600 of a normal transfer -> timing unchanged, O_DONE still at 4097.
- Reset: deassert I_RESET_L at cycle 2000 of a transfer, asynchronous to I_CLK -> all outputs 0 immediately; after release, no pulses until a new I_START.

Source files
------------

// File: rtl/serial_xfer_ctrl.sv
// Link-port transfer sequencer: times 8-bit serial transfers from an internal
// divided clock or a synchronized external clock and issues shift/load strobes.
module serial_xfer_ctrl #(
  parameter int DIV_NORMAL = 512,
  parameter int DIV_FAST   = 16,
  parameter int CNT_W      = 9
) (
  input  logic       I_CLK,
  input  logic       I_RESET_L,
  input  logic       I_START,
  input  logic       I_INTERNAL,
  input  logic       I_FAST,
  input  logic       I_ABORT,
  input  logic       I_EXTERNAL_CLOCK,
  output logic       O_SERIAL_CLOCK,
  output logic       O_OUT_LOAD,
  output logic       O_SHIFT,
  output logic       O_BUSY,
  output logic       O_DONE,
  output logic       O_SERIAL_INTERRUPT,
  output logic [2:0] O_BIT_COUNT
);

  // state  | meaning
  // IDLE   | no transfer; completion pulse may be showing
  // LOW    | internal clock low half-period, SB[7] driven out on entry
  // HIGH   | internal clock high half-period, SB shifted on entry
  // EXT    | following the synchronized external clock pin
  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_EXT} state_e;

  localparam logic [CNT_W-1:0] HALF_N = CNT_W'(DIV_NORMAL / 2 - 1);
  localparam logic [CNT_W-1:0] HALF_F = CNT_W'(DIV_FAST / 2 - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic             fast_q, fast_d;
  logic             done_q, done_d;
  logic [2:0]       sync_q;
  logic [CNT_W-1:0] half_cur;
  logic             cnt_zero;
  logic             ext_rise;
  logic             ext_fall;

  assign half_cur = fast_q ? HALF_F : HALF_N;
  assign cnt_zero = (cnt_q == '0);
  // sync_q[1] is the synchronized pin level, sync_q[2] its previous value
  assign ext_rise = sync_q[1] & ~sync_q[2];
  assign ext_fall = ~sync_q[1] & sync_q[2];

  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      fast_q  <= 1'b0;
      done_q  <= 1'b0;
      sync_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      fast_q  <= fast_d;
      done_q  <= done_d;
      sync_q  <= {sync_q[1:0], I_EXTERNAL_CLOCK};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    fast_d  = fast_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (I_START) begin
          if (I_INTERNAL) begin
            fast_d  = I_FAST;
            cnt_d   = I_FAST ? HALF_F : HALF_N;
            state_d = S_LOW;
          end else begin
            state_d = S_EXT;
          end
        end
      end
      S_LOW: begin
        if (cnt_zero) begin
          cnt_d   = half_cur;
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HIGH: begin
        if (cnt_zero) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d   = half_cur;
            state_d = S_LOW;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_EXT: begin
        if (ext_rise) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // abort overrides everything, including a completing edge
    if (I_ABORT && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      bit_d   = 3'd0;
      done_d  = 1'b0;
    end
  end

  always_comb begin
    O_SERIAL_CLOCK     = (state_q == S_HIGH);
    O_BUSY             = (state_q != S_IDLE);
    O_OUT_LOAD         = ((state_q == S_LOW) && (cnt_q == half_cur)) ||
                         ((state_q == S_EXT) && ext_fall);
    O_SHIFT            = (((state_q == S_HIGH) && (cnt_q == half_cur)) ||
                          ((state_q == S_EXT) && ext_rise)) && !I_ABORT;
    O_DONE             = done_q;
    O_SERIAL_INTERRUPT = done_q;
    O_BIT_COUNT        = bit_q;
  end

endmodule

// File: tb/tb_serial_xfer_ctrl.sv
// Bench for serial_xfer_ctrl: cycle-by-cycle comparison against a timing model
// derived from elapsed cycles and pin history, plus directed literal checks.
`timescale 1ns/1ps
module tb_serial_xfer_ctrl;

  localparam int DIV_N = 512;
  localparam int DIV_F = 16;

  logic       clk;
  logic       rst_n;
  logic       I_START, I_INTERNAL, I_FAST, I_ABORT, ext;
  logic       O_SERIAL_CLOCK, O_OUT_LOAD, O_SHIFT, O_BUSY, O_DONE, O_SERIAL_INTERRUPT;
  logic [2:0] O_BIT_COUNT;

  serial_xfer_ctrl dut (
    .I_CLK              (clk),
    .I_RESET_L          (rst_n),
    .I_START            (I_START),
    .I_INTERNAL         (I_INTERNAL),
    .I_FAST             (I_FAST),
    .I_ABORT            (I_ABORT),
    .I_EXTERNAL_CLOCK   (ext),
    .O_SERIAL_CLOCK     (O_SERIAL_CLOCK),
    .O_OUT_LOAD         (O_OUT_LOAD),
    .O_SHIFT            (O_SHIFT),
    .O_BUSY             (O_BUSY),
    .O_DONE             (O_DONE),
    .O_SERIAL_INTERRUPT (O_SERIAL_INTERRUPT),
    .O_BIT_COUNT        (O_BIT_COUNT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // model: mode 0 idle, 1 internal, 2 external
  int cyc = 0;
  int m_mode = 0;
  int m_start = 0;
  int m_div = DIV_N;
  int m_bits = 0;
  bit m_done = 1'b0;
  bit ph[$];

  function automatic bit hist(input int i);
    return (i < ph.size()) ? ph[i] : 1'b0;
  endfunction

  // a pin edge becomes visible two sampled clocks later
  function automatic bit pin_rise();
    return hist(1) && !hist(2);
  endfunction

  function automatic bit pin_fall();
    return !hist(1) && hist(2);
  endfunction

  initial forever begin : model
    int prev_mode;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_mode = 0;
      m_bits = 0;
      m_done = 1'b0;
      ph.delete();
    end else begin
      prev_mode = m_mode;
      m_done = 1'b0;
      if (prev_mode == 1) begin
        if (cyc - m_start == 8 * m_div) begin
          m_mode = 0;
          m_done = 1'b1;
        end
      end else if (prev_mode == 2 && pin_rise()) begin
        if (m_bits == 7) begin
          m_mode = 0;
          m_bits = 0;
          m_done = 1'b1;
        end else begin
          m_bits++;
        end
      end
      if (I_ABORT && prev_mode != 0) begin
        m_mode = 0;
        m_bits = 0;
        m_done = 1'b0;
      end
      if (prev_mode == 0 && I_START) begin
        if (I_INTERNAL) begin
          m_mode  = 1;
          m_start = cyc;
          m_div   = I_FAST ? DIV_F : DIV_N;
        end else begin
          m_mode = 2;
          m_bits = 0;
        end
      end
      ph.push_front(ext);
      if (ph.size() > 4) void'(ph.pop_back());
      cyc++;
    end
  end

  initial forever begin : compare
    int t, r;
    bit ab;
    logic [8:0] exp_v, act_v;
    @(negedge clk);
    if (rst_n) begin
      ab = I_ABORT && (m_mode != 0);
      case (m_mode)
        1: begin
          t = cyc - m_start;
          r = (t - 1) % m_div;
          exp_v = {r == 0, (r == m_div / 2) && !ab, r >= m_div / 2, 1'b1,
                   1'b0, 1'b0, 3'((t - 1) / m_div)};
        end
        2: exp_v = {pin_fall(), pin_rise() && !ab, 1'b0, 1'b1, 1'b0, 1'b0, 3'(m_bits)};
        default: exp_v = {1'b0, 1'b0, 1'b0, 1'b0, m_done, m_done, 3'b000};
      endcase
      act_v = {O_OUT_LOAD, O_SHIFT, O_SERIAL_CLOCK, O_BUSY, O_DONE,
               O_SERIAL_INTERRUPT, O_BIT_COUNT};
      n_checks++;
      if (act_v !== exp_v)
        $display("FAIL cycle_model cyc=%0d {load,shift,sclk,busy,done,irq,bits} got=%b want=%b",
                 cyc, act_v, exp_v);
      else
        n_pass++;
    end
  end

  // event recorder for directed literal checks, relative to start cycle s0
  int s0 = 0;
  int n_load, n_shift, n_done, n_irq, n_sclk;
  int first_load, first_shift, last_shift, done_rel;

  task automatic rec_reset();
    n_load = 0; n_shift = 0; n_done = 0; n_irq = 0; n_sclk = 0;
    first_load = -1; first_shift = -1; last_shift = -1; done_rel = -1;
  endtask

  initial forever begin : recorder
    @(negedge clk);
    if (rst_n) begin
      if (O_OUT_LOAD) begin
        n_load++;
        if (first_load < 0) first_load = cyc - s0;
      end
      if (O_SHIFT) begin
        n_shift++;
        if (first_shift < 0) first_shift = cyc - s0;
        last_shift = cyc - s0;
      end
      if (O_DONE) begin
        n_done++;
        done_rel = cyc - s0;
      end
      if (O_SERIAL_INTERRUPT) n_irq++;
      if (O_SERIAL_CLOCK) n_sclk++;
    end
  end

  task automatic check_lit(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s got=%0d want=%0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic pulse_start(input logic internal, input logic fast);
    @(posedge clk); #2;
    I_START = 1'b1; I_INTERNAL = internal; I_FAST = fast;
    s0 = cyc;
    @(posedge clk); #2;
    I_START = 1'b0;
  endtask

  task automatic goto_rel(input int r);
    repeat (s0 + r - cyc) @(posedge clk);
    #2;
  endtask

  task automatic ext_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (20) @(posedge clk);
      #($urandom_range(1, 9)); ext = 1'b0;
      repeat (20) @(posedge clk);
      #($urandom_range(1, 9)); ext = 1'b1;
    end
  endtask

  task automatic idle_out();
    @(posedge clk); #2; I_ABORT = 1'b1; I_START = 1'b0;
    @(posedge clk); #2; I_ABORT = 1'b0;
  endtask

  task automatic random_pokes(input int n, input int ab_pm, input int st_pm);
    repeat (n) begin
      @(posedge clk); #2;
      I_ABORT    = ($urandom_range(0, 999) < ab_pm);
      I_START    = ($urandom_range(0, 999) < st_pm);
      I_INTERNAL = 1'($urandom_range(0, 1));
      I_FAST     = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #2;
    I_ABORT = 1'b0; I_START = 1'b0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; I_START = 1'b0; I_INTERNAL = 1'b0; I_FAST = 1'b0;
    I_ABORT = 1'b0; ext = 1'b1;
    rec_reset();
    #12;
    check_lit("reset_outputs", int'({O_SERIAL_CLOCK, O_OUT_LOAD, O_SHIFT, O_BUSY,
                                     O_DONE, O_SERIAL_INTERRUPT, O_BIT_COUNT}), 0);
    #11 rst_n = 1'b1;

    // internal normal speed
    rec_reset();
    pulse_start(1'b1, 1'b0);
    goto_rel(4110);
    check_lit("norm_first_load", first_load, 1);
    check_lit("norm_first_shift", first_shift, 257);
    check_lit("norm_last_shift", last_shift, 3841);
    check_lit("norm_n_load", n_load, 8);
    check_lit("norm_n_shift", n_shift, 8);
    check_lit("norm_done_cycle", done_rel, 4097);
    check_lit("norm_n_irq", n_irq, 1);

    // internal fast speed
    rec_reset();
    pulse_start(1'b1, 1'b1);
    goto_rel(140);
    check_lit("fast_first_shift", first_shift, 9);
    check_lit("fast_n_shift", n_shift, 8);
    check_lit("fast_sclk_high_cycles", n_sclk, 64);
    check_lit("fast_done_cycle", done_rel, 129);

    // restart while busy is ignored
    rec_reset();
    pulse_start(1'b1, 1'b0);
    goto_rel(600);
    I_START = 1'b1; I_INTERNAL = 1'b1; I_FAST = 1'b1;
    goto_rel(601);
    I_START = 1'b0;
    goto_rel(4110);
    check_lit("restart_done_cycle", done_rel, 4097);
    check_lit("restart_n_done", n_done, 1);

    // abort mid-transfer
    rec_reset();
    pulse_start(1'b1, 1'b0);
    goto_rel(1000);
    I_ABORT = 1'b1;
    goto_rel(1001);
    I_ABORT = 1'b0;
    check_lit("abort_busy", int'(O_BUSY), 0);
    check_lit("abort_bit_count", int'(O_BIT_COUNT), 0);
    goto_rel(5000);
    check_lit("abort_n_done", n_done, 0);
    check_lit("abort_n_irq", n_irq, 0);

    // abort and start together while busy
    pulse_start(1'b1, 1'b1);
    goto_rel(50);
    I_ABORT = 1'b1; I_START = 1'b1; I_INTERNAL = 1'b1;
    goto_rel(51);
    I_ABORT = 1'b0; I_START = 1'b0;
    check_lit("abort_start_busy", int'(O_BUSY), 0);

    // external clock, full byte
    rec_reset();
    pulse_start(1'b0, 1'b0);
    ext_pulses(8);
    repeat (10) @(posedge clk);
    #2;
    check_lit("ext_n_load", n_load, 8);
    check_lit("ext_n_shift", n_shift, 8);
    check_lit("ext_n_done", n_done, 1);
    check_lit("ext_sclk_high_cycles", n_sclk, 0);

    // external clock, only seven pulses
    rec_reset();
    pulse_start(1'b0, 1'b0);
    ext_pulses(7);
    repeat (500) @(posedge clk);
    #2;
    check_lit("ext7_busy", int'(O_BUSY), 1);
    check_lit("ext7_bit_count", int'(O_BIT_COUNT), 7);
    check_lit("ext7_n_done", n_done, 0);
    idle_out();

    // abort coinciding with a detected rising edge
    rec_reset();
    pulse_start(1'b0, 1'b0);
    ext_pulses(2);
    repeat (20) @(posedge clk);
    #3 ext = 1'b0;
    repeat (20) @(posedge clk);
    #3 ext = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    I_ABORT = 1'b1;
    @(posedge clk); #2;
    I_ABORT = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check_lit("ext_abort_n_shift", n_shift, 2);
    check_lit("ext_abort_n_done", n_done, 0);

    // asynchronous reset mid-transfer
    rec_reset();
    pulse_start(1'b1, 1'b0);
    goto_rel(2000);
    #1 rst_n = 1'b0;
    #1;
    check_lit("midreset_outputs", int'({O_SERIAL_CLOCK, O_OUT_LOAD, O_SHIFT, O_BUSY,
                                       O_DONE, O_SERIAL_INTERRUPT, O_BIT_COUNT}), 0);
    repeat (3) @(posedge clk);
    #6 rst_n = 1'b1;
    rec_reset();
    repeat (300) @(posedge clk);
    #2;
    check_lit("postreset_pulses", n_load + n_shift + n_done + n_irq, 0);

    // randomized traffic against the model
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 3) == 3) begin
        pulse_start(1'b0, 1'($urandom_range(0, 1)));
        fork
          ext_pulses($urandom_range(6, 9));
          random_pokes(360, 1, 3);
        join
      end else begin
        pulse_start(1'b1, 1'b1);
        random_pokes($urandom_range(100, 200), 3, 10);
      end
      idle_out();
    end

    repeat (5) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
